// File: rtl/uart_tx_if.sv
// Byte/strobe handshake between user logic and the UART transmitter.
// The master side is the user logic; the slave side is uart_tx itself.
interface uart_tx_if;
  logic       i_enable;
  logic [7:0] i_txdata;
  logic       i_send;
  logic       o_dout;
  logic       o_busy;
  logic       o_done;

  modport master (
    output i_enable, i_txdata, i_send,
    input  o_dout, o_busy, o_done
  );

  modport slave (
    input  i_enable, i_txdata, i_send,
    output o_dout, o_busy, o_done
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, line idles high, every bit TICKS_PER_BIT clocks.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and stop.
module uart_tx #(
  parameter int TICKS_PER_BIT      = 32,
  parameter int TICKS_PER_BIT_SIZE = 6
) (
  input  logic     i_clk,
  input  logic     i_rst,
  uart_tx_if.slave bus
);

  localparam logic [TICKS_PER_BIT_SIZE-1:0] TICK_LAST =
    TICKS_PER_BIT_SIZE'(TICKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_START  = 6'b000010,
    S_DATA   = 6'b000100,
    S_PARITY = 6'b001000,
    S_STOP   = 6'b010000,
    S_DONE   = 6'b100000
  } state_t;
`else
  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_START = 5'b00010,
    S_DATA  = 5'b00100,
    S_STOP  = 5'b01000,
    S_DONE  = 5'b10000
  } state_t;
`endif

  state_t                        state_q, state_d;
  logic [TICKS_PER_BIT_SIZE-1:0] tick_q, tick_d;
  logic [3:0]                    bit_cnt_q, bit_cnt_d;
  logic [7:0]                    shift_q, shift_d;
  logic                          dout_q, dout_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          tick_last;
`ifdef UART_TX_PARITY_EN
  logic                          parity_q, parity_d;
`endif

  assign tick_last  = (tick_q == TICK_LAST);
  assign bus.o_dout = dout_q;
  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;

  // Outputs are computed for the *next* state so the pin changes on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    dout_d    = dout_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        dout_d = 1'b1;
        busy_d = 1'b0;
        if (bus.i_enable && bus.i_send) begin
          shift_d   = bus.i_txdata;
          tick_d    = '0;
          bit_cnt_d = '0;
          dout_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_START;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^bus.i_txdata;
`endif
        end
      end
      S_START: begin
        if (tick_last) begin
          tick_d  = '0;
          dout_d  = shift_q[0];
          state_d = S_DATA;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tick_last) begin
          tick_d    = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
`ifdef UART_TX_PARITY_EN
            dout_d  = parity_q;
            state_d = S_PARITY;
`else
            dout_d  = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            dout_d = shift_q[1];
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick_last) begin
          tick_d  = '0;
          dout_d  = 1'b1;
          state_d = S_STOP;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (tick_last) begin
          tick_d  = '0;
          dout_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_DONE: begin
        dout_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        tick_d    = '0;
        bit_cnt_d = '0;
        dout_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      dout_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx; the line is recorded cycle by cycle and frames
// are decoded at mid-bit. Define UART_TX_PARITY_EN to exercise the parity build.
module tb_uart_tx;

  localparam int TPB      = 16;
  localparam int TPB_SIZE = 5;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * TPB;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  uart_tx_if bus ();

  uart_tx #(
    .TICKS_PER_BIT      (TPB),
    .TICKS_PER_BIT_SIZE (TPB_SIZE)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  int   check_count = 0;
  int   pass_count  = 0;
  int   fail_count  = 0;
  logic line_hist [0:511];
  int   done_at [$];
  int   busy_cnt;

  // Every step lands 1 time unit after a rising edge, where inputs are driven and outputs sampled.
  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic en, input logic send, input logic [7:0] data);
    bus.i_enable = en;
    bus.i_send   = send;
    bus.i_txdata = data;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_hist();
    done_at.delete();
    busy_cnt = 0;
  endtask

  task automatic record(input int first, input int n);
    for (int c = first; c < first + n; c++) begin
      line_hist[c] = bus.o_dout;
      if (bus.o_done === 1'b1) done_at.push_back(c);
      if (bus.o_busy === 1'b1) busy_cnt++;
      step(1);
    end
  endtask

  function automatic int count_low(input int first, input int n);
    int k = 0;
    for (int c = first; c < first + n; c++) if (line_hist[c] !== 1'b1) k++;
    return k;
  endfunction

  function automatic logic [10:0] decode(input int start);
    logic [10:0] d = '0;
    for (int i = 0; i < FRAME_BITS; i++) d[i] = line_hist[start + TPB * i + TPB / 2];
    return d;
  endfunction

  function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b0, 1'b1, b, 1'b0};
`endif
  endfunction

  function automatic int done_pos(input int idx);
    return (done_at.size() > idx) ? done_at[idx] : -1;
  endfunction

  initial begin
    $display("[TB] start, TICKS_PER_BIT=%0d frame=%0d cycles", TPB, FRAME_CYC);
    apply_stimulus(1'b0, 1'b0, 8'h00);
    i_rst = 1'b1;
    step(3);
    check_output("reset_dout", bus.o_dout, 1);
    check_output("reset_busy", bus.o_busy, 0);
    check_output("reset_done", bus.o_done, 0);
    i_rst = 1'b0;

    clear_hist();
    record(0, 200);
    check_output("idle_low_cycles", count_low(0, 200), 0);
    check_output("idle_busy_cycles", busy_cnt, 0);
    check_output("idle_done_pulses", done_at.size(), 0);

    // Single frame 0xA5; txdata changed right after acceptance must not matter
    apply_stimulus(1'b1, 1'b1, 8'hA5);
    step(1);
    apply_stimulus(1'b1, 1'b0, 8'h00);
    clear_hist();
    record(1, FRAME_CYC + 10);
    check_output("a5_first_cycle_low", line_hist[1], 0);
    check_output("a5_frame", decode(1), frame_of(8'hA5));
`ifndef UART_TX_PARITY_EN
    check_output("a5_frame_literal", decode(1), 11'b0_1_1010_0101_0);
`endif
    check_output("a5_done_pulses", done_at.size(), 1);
    check_output("a5_done_cycle", done_pos(0), FRAME_CYC + 1);
    check_output("a5_busy_cycles", busy_cnt, FRAME_CYC + 1);

    // Back-to-back with i_send held high
    apply_stimulus(1'b1, 1'b1, 8'h00);
    step(1);
    bus.i_txdata = 8'hFF;
    clear_hist();
    record(1, 2 * FRAME_CYC + 3);
    bus.i_send = 1'b0;
    record(2 * FRAME_CYC + 4, 5);
    check_output("b2b_gap_high", line_hist[FRAME_CYC + 2], 1);
    check_output("b2b_second_start", line_hist[FRAME_CYC + 3], 0);
    check_output("b2b_frame0", decode(1), frame_of(8'h00));
    check_output("b2b_frame1", decode(FRAME_CYC + 3), frame_of(8'hFF));
    check_output("b2b_done_pulses", done_at.size(), 2);
    check_output("b2b_done1_cycle", done_pos(1), 2 * FRAME_CYC + 3);
    check_output("b2b_busy_cycles", busy_cnt, 2 * (FRAME_CYC + 1));

    // Requests while busy are dropped
    apply_stimulus(1'b1, 1'b1, 8'h3C);
    step(1);
    apply_stimulus(1'b1, 1'b0, 8'h3C);
    clear_hist();
    record(1, 49);
    apply_stimulus(1'b1, 1'b1, 8'hC3);
    record(50, 1);
    apply_stimulus(1'b1, 1'b0, 8'hC3);
    record(51, 49);
    apply_stimulus(1'b1, 1'b1, 8'hC3);
    record(100, 1);
    apply_stimulus(1'b1, 1'b0, 8'hC3);
    record(101, FRAME_CYC + 10 - 100);
    check_output("ign_frame", decode(1), frame_of(8'h3C));
    check_output("ign_done_pulses", done_at.size(), 1);
    check_output("ign_busy_cycles", busy_cnt, FRAME_CYC + 1);

    // Disabled: send is not accepted
    apply_stimulus(1'b0, 1'b1, 8'h81);
    clear_hist();
    record(1, 40);
    check_output("dis_low_cycles", count_low(1, 40), 0);
    check_output("dis_busy_cycles", busy_cnt, 0);
    apply_stimulus(1'b1, 1'b0, 8'h00);
    step(1);

    // Enable dropped mid-frame: frame still completes
    apply_stimulus(1'b1, 1'b1, 8'h55);
    step(1);
    apply_stimulus(1'b1, 1'b0, 8'h55);
    clear_hist();
    record(1, 39);
    bus.i_enable = 1'b0;
    record(40, FRAME_CYC + 10 - 39);
    check_output("en_drop_frame", decode(1), frame_of(8'h55));
    check_output("en_drop_done_cycle", done_pos(0), FRAME_CYC + 1);
    bus.i_enable = 1'b1;
    step(1);

    // Reset mid-frame forces the line high at once
    apply_stimulus(1'b1, 1'b1, 8'hF0);
    step(1);
    apply_stimulus(1'b1, 1'b0, 8'hF0);
    clear_hist();
    record(1, 69);
    check_output("rst_pre_line_low", line_hist[69], 0);
    i_rst = 1'b1;
    #1;
    check_output("rst_mid_dout", bus.o_dout, 1);
    check_output("rst_mid_busy", bus.o_busy, 0);
    step(3);
    i_rst = 1'b0;
    step(1);
    apply_stimulus(1'b1, 1'b1, 8'h96);
    step(1);
    apply_stimulus(1'b1, 1'b0, 8'h00);
    clear_hist();
    record(1, FRAME_CYC + 10);
    check_output("post_rst_frame", decode(1), frame_of(8'h96));
    check_output("post_rst_done_cycle", done_pos(0), FRAME_CYC + 1);

`ifdef UART_TX_PARITY_EN
    apply_stimulus(1'b1, 1'b1, 8'h07);
    step(1);
    apply_stimulus(1'b1, 1'b0, 8'h00);
    clear_hist();
    record(1, FRAME_CYC + 10);
    check_output("par07_frame", decode(1), 11'b1_1_0000_0111_0);
    check_output("par07_done_cycle", done_pos(0), 11 * TPB + 1);
    apply_stimulus(1'b1, 1'b1, 8'h03);
    step(1);
    apply_stimulus(1'b1, 1'b0, 8'h00);
    clear_hist();
    record(1, FRAME_CYC + 10);
    check_output("par03_frame", decode(1), 11'b1_0_0000_0011_0);
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
